// File: rtl/serializador_izq_der.sv
// Bit-serial feeder and collector for single-bit gate stages. It presents operand bit pairs
// MSB-first (izq) or LSB-first (der) and rebuilds the gate's serial output into a word.
module serializador_izq_der #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iniciar,
  input  logic             direccion,
  input  logic [ANCHO-1:0] dato_a,
  input  logic [ANCHO-1:0] dato_b,
  input  logic             resultado_bit,
  output logic             bit_a,
  output logic             bit_b,
  output logic             valido,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] resultado
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] DESPLAZA = 2'd1;
  localparam logic [1:0] COMPLETO = 2'd2;

  logic [1:0]       estado_r;
  logic             dir_r;
  logic [CW-1:0]    cnt_r;
  logic [ANCHO-1:0] a_sh_r;
  logic [ANCHO-1:0] b_sh_r;
  logic [ANCHO-1:0] acc_r;

  logic [CW-1:0]    idx_s;
  logic [ANCHO-1:0] acc_s;
  logic             sig_a_s;
  logic             sig_b_s;
  logic [ANCHO-1:0] a_desp_s;
  logic [ANCHO-1:0] b_desp_s;

  // Result bit index follows the pair on the wire, so resultado[k] pairs with operand bit k.
  always_comb begin
    idx_s = ULTIMO;
    acc_s = acc_r;
    if (dir_r) begin
      idx_s = cnt_r;
    end else begin
      idx_s = ULTIMO - cnt_r;
    end
    for (int k = 0; k < ANCHO; k++) begin
      if (idx_s == CW'(k)) begin
        acc_s[k] = resultado_bit;
      end else begin
        acc_s[k] = acc_r[k];
      end
    end
  end

  // Next pair comes from the edge of the shift registers facing the chosen direction.
  always_comb begin
    sig_a_s  = 1'b0;
    sig_b_s  = 1'b0;
    a_desp_s = a_sh_r;
    b_desp_s = b_sh_r;
    if (dir_r) begin
      sig_a_s  = a_sh_r[0];
      sig_b_s  = b_sh_r[0];
      a_desp_s = a_sh_r >> 1'b1;
      b_desp_s = b_sh_r >> 1'b1;
    end else begin
      sig_a_s  = a_sh_r[ANCHO-1];
      sig_b_s  = b_sh_r[ANCHO-1];
      a_desp_s = a_sh_r << 1'b1;
      b_desp_s = b_sh_r << 1'b1;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r  <= REPOSO;
      dir_r     <= 1'b0;
      cnt_r     <= '0;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      acc_r     <= '0;
      bit_a     <= 1'b0;
      bit_b     <= 1'b0;
      valido    <= 1'b0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      resultado <= '0;
    end else begin
      case (estado_r)
        REPOSO: begin
          listo <= 1'b0;
          if (iniciar) begin
            dir_r     <= direccion;
            cnt_r     <= '0;
            acc_r     <= '0;
            resultado <= '0;
            ocupado   <= 1'b1;
            valido    <= 1'b1;
            estado_r  <= DESPLAZA;
            if (direccion) begin
              bit_a  <= dato_a[0];
              bit_b  <= dato_b[0];
              a_sh_r <= dato_a >> 1'b1;
              b_sh_r <= dato_b >> 1'b1;
            end else begin
              bit_a  <= dato_a[ANCHO-1];
              bit_b  <= dato_b[ANCHO-1];
              a_sh_r <= dato_a << 1'b1;
              b_sh_r <= dato_b << 1'b1;
            end
          end else begin
            valido   <= 1'b0;
            ocupado  <= 1'b0;
            estado_r <= REPOSO;
          end
        end
        DESPLAZA: begin
          acc_r <= acc_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == ULTIMO) begin
            valido    <= 1'b0;
            listo     <= 1'b1;
            resultado <= acc_s;
            estado_r  <= COMPLETO;
          end else begin
            bit_a    <= sig_a_s;
            bit_b    <= sig_b_s;
            a_sh_r   <= a_desp_s;
            b_sh_r   <= b_desp_s;
            estado_r <= DESPLAZA;
          end
        end
        COMPLETO: begin
          listo    <= 1'b0;
          ocupado  <= 1'b0;
          valido   <= 1'b0;
          estado_r <= REPOSO;
        end
        default: begin
          listo    <= 1'b0;
          ocupado  <= 1'b0;
          valido   <= 1'b0;
          estado_r <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_izq_der.sv
// Bench for serializador_izq_der: a word-level timeline model checked every cycle,
// plus literal expectations for each directed scenario, on an 8-bit and a 1-bit instance.
module tb_serializador_izq_der;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         iniciar = 1'b0;
  logic         direccion = 1'b0;
  logic [N-1:0] dato_a = '0;
  logic [N-1:0] dato_b = '0;
  logic [1:0]   op = 2'd0;
  logic         resultado_bit;
  logic         bit_a, bit_b, valido, ocupado, listo;
  logic [N-1:0] resultado;

  logic         iniciar1 = 1'b0;
  logic [0:0]   a1 = 1'b1;
  logic [0:0]   b1 = 1'b1;
  logic         rb1;
  logic         bit_a1, bit_b1, valido1, ocupado1, listo1;
  logic [0:0]   resultado1;

  int checks = 0;
  int errors = 0;

  function automatic logic [N-1:0] gate_word(input logic [1:0] s, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      default: return ~a & b;
    endcase
  endfunction

  assign resultado_bit = gate_word(op, {{(N-1){1'b0}}, bit_a}, {{(N-1){1'b0}}, bit_b}) != '0;
  assign rb1 = bit_a1 & bit_b1;

  serializador_izq_der #(.ANCHO(N)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .direccion(direccion),
    .dato_a(dato_a), .dato_b(dato_b), .resultado_bit(resultado_bit),
    .bit_a(bit_a), .bit_b(bit_b), .valido(valido), .ocupado(ocupado),
    .listo(listo), .resultado(resultado)
  );

  serializador_izq_der #(.ANCHO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar1), .direccion(1'b1),
    .dato_a(a1), .dato_b(b1), .resultado_bit(rb1),
    .bit_a(bit_a1), .bit_b(bit_b1), .valido(valido1), .ocupado(ocupado1),
    .listo(listo1), .resultado(resultado1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k counts cycles since the accepting edge (0 = idle).
  int           k;
  logic [N-1:0] ma, mb, exp_res;
  logic         md;
  logic [1:0]   mop;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      exp_res <= '0;
    end else if (k == 0) begin
      if (iniciar) begin
        k <= 1; ma <= dato_a; mb <= dato_b; md <= direccion; mop <= op; exp_res <= '0;
      end
    end else if (k == N + 1) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if (k == N) exp_res <= gate_word(mop, ma, mb);
    end
  end

  logic [N-1:0] seq;
  always @(negedge clk) begin
    chk("valido", 32'(valido), 32'(k >= 1 && k <= N));
    chk("ocupado", 32'(ocupado), 32'(k >= 1 && k <= N + 1));
    chk("listo", 32'(listo), 32'(k == N + 1));
    chk("resultado", 32'(resultado), 32'(exp_res));
    if (k >= 1 && k <= N) begin
      chk("bit_a", 32'(bit_a), 32'(md ? ma[k-1] : ma[N-k]));
      chk("bit_b", 32'(bit_b), 32'(md ? mb[k-1] : mb[N-k]));
    end
    if (!rst_n) begin
      chk("bit_a_rst", 32'(bit_a), 32'd0);
      chk("bit_b_rst", 32'(bit_b), 32'd0);
    end
    if (valido) seq <= {seq[N-2:0], bit_a};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic d,
                        input logic [1:0] s, input logic [N-1:0] exp, input string name);
    dato_a = a; dato_b = b; direccion = d; op = s; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    repeat (N) step();
    chk({name, "_listo"}, 32'(listo), 32'd1);
    chk({name, "_res"}, 32'(resultado), 32'(exp));
    chk({name, "_seq"}, 32'(seq), 32'h000000A5);
    step();
  endtask

  initial begin
    repeat (2) step();
    chk("rst_valido", 32'(valido), 32'd0);
    chk("rst_res", 32'(resultado), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(8'hA5, 8'h3C, 1'b0, 2'd0, 8'h24, "and_izq");
    run_op(8'hA5, 8'h3C, 1'b1, 2'd1, 8'hBD, "or_der");
    run_op(8'hA5, 8'h3C, 1'b0, 2'd2, 8'h18, "nega_izq");
    run_op(8'hA5, 8'h3C, 1'b1, 2'd2, 8'h18, "nega_der");

    // iniciar during DESPLAZA and COMPLETO is ignored
    dato_a = 8'hA5; dato_b = 8'h3C; direccion = 1'b0; op = 2'd0; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    repeat (2) step();
    iniciar = 1'b1; dato_a = 8'hFF; dato_b = 8'hFF;
    step();
    iniciar = 1'b0;
    repeat (5) step();
    chk("ign_listo9", 32'(listo), 32'd1);
    iniciar = 1'b1;
    step();
    chk("ign_res10", 32'(resultado), 32'h24);
    chk("ign_ocup10", 32'(ocupado), 32'd0);
    step();
    iniciar = 1'b0;
    chk("acc_valido", 32'(valido), 32'd1);
    repeat (N) step();
    chk("acc_res", 32'(resultado), 32'hFF);
    step();

    // reset in cycle 4 of an operation
    dato_a = 8'hA5; dato_b = 8'h3C; direccion = 1'b1; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_all", 32'({valido, ocupado, listo, bit_a, bit_b}), 32'd0);
    chk("mid_rst_res", 32'(resultado), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (N + 2) step();
    chk("mid_rst_nolisto", 32'(listo), 32'd0);
    run_op(8'hA5, 8'h3C, 1'b0, 2'd0, 8'h24, "post_rst");

    // single-bit instance
    iniciar1 = 1'b1;
    step();
    iniciar1 = 1'b0;
    chk("w1_valido1", 32'(valido1), 32'd1);
    chk("w1_bits", 32'({bit_a1, bit_b1}), 32'd3);
    chk("w1_listo1", 32'(listo1), 32'd0);
    step();
    chk("w1_valido2", 32'(valido1), 32'd0);
    chk("w1_listo2", 32'(listo1), 32'd1);
    chk("w1_res", 32'(resultado1), 32'd1);
    step();
    chk("w1_idle", 32'({listo1, ocupado1}), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serializador_izq_der.md
Name: serializador_izq_der

Overview:
- Bit-serial operand feeder and result collector for the single-bit gate stages (AND, OR, negated-A multiplier).
- Takes two ANCHO-bit operands and presents one bit of each per cycle on bit_a/bit_b, in a selectable direction: izq = MSB first, der = LSB first.
- Captures the downstream gate's 1-bit output each cycle and reassembles it into an ANCHO-bit word.
- Sits directly upstream of the gate stage, feeding its a/b inputs, and directly downstream of its output.

Parameters:
ANCHO, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
iniciar  input  1  start request; sampled only in REPOSO
direccion  input  1  0 = izq (MSB first), 1 = der (LSB first); latched on accepted iniciar
dato_a  input  ANCHO  operand A; latched on accepted iniciar
dato_b  input  ANCHO  operand B; latched on accepted iniciar
resultado_bit  input  1  combinational output of downstream gate stage
bit_a  output  1  current serial bit of A to gate input a
bit_b  output  1  current serial bit of B to gate input b
valido  output  1  bit_a/bit_b are a live pair this cycle
ocupado  output  1  high from accepted iniciar through COMPLETO
listo  output  1  one-cycle pulse: resultado is complete
resultado  output  ANCHO  reassembled gate output word

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - state = REPOSO.
  - bit_a, bit_b, valido, ocupado, listo = 0.
  - resultado = 0; internal shift registers and counter = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: REPOSO, DESPLAZA, COMPLETO.
- REPOSO:
  - On iniciar = 1 at an edge: latch dato_a, dato_b, direccion; clear counter and result register; ocupado <= 1.
  - Load the first bit pair onto bit_a/bit_b, set valido <= 1, go to DESPLAZA.
  - On iniciar = 0: stay in REPOSO; outputs hold, with valido = 0 and listo = 0.
- DESPLAZA, one bit pair per cycle:
  - izq presents A/B bit indices ANCHO-1 down to 0; der presents 0 up to ANCHO-1.
  - At each edge while valido = 1, sample resultado_bit into the result register at the same bit index as the pair currently presented. Hence resultado[k] = f(dato_a[k], dato_b[k]) regardless of direction.
  - The counter increments per sampled bit.
  - After the ANCHO-th sample: valido <= 0, resultado <= assembled word, listo <= 1, go to COMPLETO.
- COMPLETO (one cycle):
  - listo = 1, ocupado = 1.
  - Next edge: listo <= 0, ocupado <= 0, go to REPOSO.
- Latency: iniciar accepted at edge 0.
  - valido high for cycles 1..ANCHO.
  - listo high in cycle ANCHO+1.
  - Next iniciar accepted no earlier than the edge ending cycle ANCHO+1, giving a total of ANCHO+2 cycles per operation.
- resultado holds its value until the next accepted iniciar, then clears.
- iniciar in DESPLAZA or COMPLETO is ignored; latched operands and direction are unaffected.
- Changes to dato_a, dato_b or direccion after acceptance have no effect.
- ANCHO = 1: exactly one valido cycle; direccion is irrelevant.
- Reset asserted mid-operation: immediate return to reset values; partial result discarded; no listo pulse.
- Counter width: clog2(ANCHO+1) bits; no wrap occurs within legal ANCHO.

Test Plan:
1. AND stage, ANCHO = 8, dato_a = 8'hA5, dato_b = 8'h3C, direccion = 0 -> bit_a sequence 1,0,1,0,0,1,0,1; 8 valido cycles; listo in cycle 9; resultado = 8'h24.
2. OR stage, same operands, direccion = 1 -> bit_a sequence 1,0,1,0,0,1,0,1 LSB first; resultado = 8'hBD; ocupado high cycles 1..9.
3. Negated-A multiplier stage, same operands, direccion = 0 -> resultado = 8'h18. Repeat with direccion = 1 -> resultado = 8'h18 (direction-independent).
4. Pulse iniciar in cycles 3 and 9 (COMPLETO) with new operands 8'hFF/8'hFF -> both ignored; resultado = 8'h24 (AND). iniciar in cycle 10 is accepted.
5. rst_n low in cycle 4 of an operation -> valido, ocupado, listo, bit_a, bit_b and resultado all 0 immediately; no listo pulse. A fresh iniciar after release completes normally.
6. ANCHO = 1, dato_a = 1, dato_b = 1, AND stage -> one valido cycle; listo in cycle 2; resultado = 1'b1.
